// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: frame-sequencer state encodings, data width and bit-period math.
// Used by the transmit arbiter and reusable by a future receiver.
package uart_tx_arbiter_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int UART_DATA_BITS = 8;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  function automatic int clks_per_bit(input int freq_clkin, input int baud_rate);
    return freq_clkin / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick
// on the last count. Clearing re-phases the bit timing to the current cycle.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_divider
    $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester 8N1 UART transmitter with round-robin arbitration.
// Each frame's bit timing is phase-aligned to the cycle its byte was accepted.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int FREQ_CLKIN = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  localparam int CLKS_PER_BIT = clks_per_bit(FREQ_CLKIN, BAUD_RATE);
  localparam int BIT_CNT_W    = $clog2(UART_DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(UART_DATA_BITS - 1);

  logic [1:0]           state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  uart_byte_t           shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic winner;
  logic idle;
  logic handshake;
  logic tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(handshake),
    .en   (!idle),
    .tick (tick)
  );

  // Ties go to the requester that was not served last; a lone requester always wins.
  // Readies are suppressed during reset, since a handshake there would be discarded.
  always_comb begin
    idle       = (state_q == S_IDLE);
    winner     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = rst_n && idle && req0_valid && !winner;
    req1_ready = rst_n && idle && req1_valid &&  winner;
    handshake  = req0_ready || req1_ready;
  end

  // NOTE: every next-state variable takes its current value first, so no path leaves one
  // unassigned and no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          shift_d      = winner ? req1_data : req0_data;
          grant_d      = winner;
          last_grant_d = winner;
          bit_cnt_d    = '0;
          tx_d         = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a frame-position model checked every cycle, plus directed
// transactions whose serial bytes, grant order and handshake spacing are checked literally.
module tb_uart_tx_arbiter;

  localparam int FREQ = 40;
  localparam int BAUD = 10;
  localparam int CPB  = FREQ / BAUD;
  localparam int FRAME_CYCLES = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx, busy, grant_id;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  uart_tx_arbiter #(
    .FREQ_CLKIN(FREQ),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: m_pos is the position inside the 40-cycle frame (-1 when idle).
  bit         m_known = 1'b0;
  int         m_pos   = -1;
  logic       m_last  = 1'b1;
  logic       m_gid   = 1'b0;
  logic [7:0] m_byte  = 8'h00;

  function automatic logic m_winner();
    if (req0_valid && req1_valid) return ~m_last;
    return req1_valid;
  endfunction

  function automatic logic m_tx();
    int k;
    if (m_pos < 0) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known <= 1'b1;
      m_pos   <= -1;
      m_last  <= 1'b1;
      m_gid   <= 1'b0;
    end else if (m_known) begin
      if (m_pos >= 0) begin
        m_pos <= (m_pos == FRAME_CYCLES - 1) ? -1 : m_pos + 1;
      end else if (req0_valid || req1_valid) begin
        m_byte <= m_winner() ? req1_data : req0_data;
        m_gid  <= m_winner();
        m_last <= m_winner();
        m_pos  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("model_tx",         32'(tx),         32'(m_tx()));
      check("model_busy",       32'(busy),       32'(m_pos >= 0));
      check("model_grant_id",   32'(grant_id),   32'(m_gid));
      check("model_req0_ready", 32'(req0_ready),
            32'(rst_n && m_pos < 0 && req0_valid && !m_winner()));
      check("model_req1_ready", 32'(req1_ready),
            32'(rst_n && m_pos < 0 && req1_valid && m_winner()));
    end
  end

  // Called at a negedge; returns at the negedge where the chosen ready is high.
  task automatic wait_ready(input int which, output int t);
    int n;
    n = 0;
    while ((((which == 0) ? req0_ready : req1_ready) !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (n >= 100) check($sformatf("ready%0d_timeout", which), 32'd0, 32'd1);
  endtask

  // Samples the middle of each data bit; returns at the negedge of the first idle cycle.
  task automatic decode(input string name, input logic [7:0] exp_byte);
    logic [7:0] b;
    b = 8'h00;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat ((k == 0) ? 6 : 4) @(negedge clk);
      b[k] = tx;
    end
    repeat (6) @(negedge clk);
    check(name, 32'(b), 32'(exp_byte));
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2, t3;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'hA5;
    req1_data  = 8'h3C;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx",         32'(tx),         32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_grant_id",   32'(grant_id),   32'd0);

    // Both requesters contend continuously: req0, req1, req0.
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    wait_ready(0, t0);
    decode("rr_byte0", 8'hA5);
    check("rr_grant0", 32'(grant_id), 32'd0);
    wait_ready(1, t1);
    check("rr_spacing01", 32'(t1 - t0), 32'd41);
    decode("rr_byte1", 8'h3C);
    check("rr_grant1", 32'(grant_id), 32'd1);
    wait_ready(0, t2);
    check("rr_spacing12", 32'(t2 - t1), 32'd41);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    decode("rr_byte2", 8'hA5);
    check("rr_grant2", 32'(grant_id), 32'd0);

    // Single byte 0x55 from req0.
    @(posedge clk); #1 req0_valid = 1'b1; req0_data = 8'h55;
    @(negedge clk);
    wait_ready(0, t0);
    @(posedge clk); #1 req0_valid = 1'b0;
    decode("byte_55", 8'h55);
    check("byte_55_grant", 32'(grant_id), 32'd0);

    // Data changes right after the handshake must not reach the line.
    @(posedge clk); #1 req0_valid = 1'b1; req0_data = 8'h12;
    @(negedge clk);
    wait_ready(0, t0);
    @(posedge clk); #1 req0_data = 8'hFF; req0_valid = 1'b0;
    decode("byte_12_held", 8'h12);

    // Reset during data bit 3 aborts the frame.
    @(posedge clk); #1 req0_valid = 1'b1; req0_data = 8'hC3;
    @(negedge clk);
    wait_ready(0, t0);
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_tx",   32'(tx),   32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; req1_valid = 1'b1; req1_data = 8'h81;
    @(negedge clk);
    wait_ready(1, t0);
    @(posedge clk); #1 req1_valid = 1'b0;
    decode("after_abort_81", 8'h81);
    check("after_abort_grant", 32'(grant_id), 32'd1);

    // req1 alone streams three bytes back-to-back.
    @(posedge clk); #1 req1_valid = 1'b1; req1_data = 8'h01;
    @(negedge clk);
    wait_ready(1, t1);
    @(posedge clk); #1 req1_data = 8'h02;
    decode("solo_byte1", 8'h01);
    wait_ready(1, t2);
    check("solo_spacing12", 32'(t2 - t1), 32'd41);
    @(posedge clk); #1 req1_data = 8'h03;
    decode("solo_byte2", 8'h02);
    wait_ready(1, t3);
    check("solo_spacing23", 32'(t3 - t2), 32'd41);
    @(posedge clk); #1 req1_valid = 1'b0;
    decode("solo_byte3", 8'h03);
    check("solo_grant", 32'(grant_id), 32'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
